// File: rtl/sodor_mem_arbiter.sv
// Arbitrates the Sodor fetch (imem) and data (dmem) ports onto a single shared scratchpad port.
// One transaction is outstanding at a time; starvation guard and response timeout included.
module sodor_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        io_imem_req_valid,
    output logic        io_imem_req_ready,
    input  logic [31:0] io_imem_req_bits_addr,
    output logic        io_imem_resp_valid,
    output logic [31:0] io_imem_resp_bits_data,

    input  logic        io_dmem_req_valid,
    output logic        io_dmem_req_ready,
    input  logic [31:0] io_dmem_req_bits_addr,
    input  logic [31:0] io_dmem_req_bits_data,
    input  logic        io_dmem_req_bits_fcn,
    input  logic [2:0]  io_dmem_req_bits_typ,
    output logic        io_dmem_resp_valid,
    output logic [31:0] io_dmem_resp_bits_data,

    output logic        io_mem_req_valid,
    output logic [31:0] io_mem_req_bits_addr,
    output logic [31:0] io_mem_req_bits_data,
    output logic        io_mem_req_bits_fcn,
    output logic [2:0]  io_mem_req_bits_typ,
    input  logic        io_mem_resp_valid,
    input  logic [31:0] io_mem_resp_bits_data,

    output logic        io_timeout
);

    localparam logic [2:0] StarveMax = 3'(STARVE_LIMIT);
    localparam logic [6:0] WaitLast  = 7'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StWaitI, StWaitD} state_e;

    state_e     state_q, state_d;
    logic [2:0] starve_q, starve_d;
    logic [6:0] wait_q, wait_d;
    logic       timeout_q, timeout_d;

    logic grant_imem, grant_dmem;
    logic in_wait, resp_hit, timeout_hit;

    // Arbitration: dmem normally wins unless imem has lost STARVE_LIMIT times in a row.
    always_comb begin
        grant_imem = 1'b0;
        grant_dmem = 1'b0;
        if (state_q == StIdle && !reset) begin
            if (io_dmem_req_valid && !(io_imem_req_valid && starve_q == StarveMax)) begin
                grant_dmem = 1'b1;
            end else if (io_imem_req_valid) begin
                grant_imem = 1'b1;
            end
        end
    end

    always_comb begin
        in_wait     = (state_q == StWaitI) || (state_q == StWaitD);
        resp_hit    = in_wait && io_mem_resp_valid;
        timeout_hit = in_wait && !io_mem_resp_valid && (wait_q == WaitLast);
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            starve_q  <= 3'd0;
            wait_q    <= 7'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        unique case (state_q)
            StIdle: begin
                wait_d = 7'd0;
                if (grant_imem) begin
                    state_d  = StWaitI;
                    starve_d = 3'd0;
                end else if (grant_dmem) begin
                    state_d = StWaitD;
                    if (io_imem_req_valid && starve_q != 3'd7) begin
                        starve_d = starve_q + 3'd1;
                    end
                end
            end
            StWaitI, StWaitD: begin
                if (resp_hit) begin
                    state_d = StIdle;
                end else if (timeout_hit) begin
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + 7'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        io_imem_req_ready = grant_imem;
        io_dmem_req_ready = grant_dmem;
        io_mem_req_valid  = grant_imem || grant_dmem;

        if (grant_imem) begin
            io_mem_req_bits_addr = io_imem_req_bits_addr;
            io_mem_req_bits_data = 32'h0;
            io_mem_req_bits_fcn  = 1'b0;
            io_mem_req_bits_typ  = 3'd3;
        end else begin
            io_mem_req_bits_addr = io_dmem_req_bits_addr;
            io_mem_req_bits_data = io_dmem_req_bits_data;
            io_mem_req_bits_fcn  = io_dmem_req_bits_fcn;
            io_mem_req_bits_typ  = io_dmem_req_bits_typ;
        end

        io_imem_resp_valid = !reset && (state_q == StWaitI) && (resp_hit || timeout_hit);
        io_dmem_resp_valid = !reset && (state_q == StWaitD) && (resp_hit || timeout_hit);

        // Owner sees zero data on a timeout abort; otherwise the scratchpad data passes through.
        io_imem_resp_bits_data = (timeout_hit && state_q == StWaitI) ? 32'h0
                                                                     : io_mem_resp_bits_data;
        io_dmem_resp_bits_data = (timeout_hit && state_q == StWaitD) ? 32'h0
                                                                     : io_mem_resp_bits_data;

        io_timeout = timeout_q && !reset;
    end

endmodule

// File: tb/tb_sodor_mem_arbiter.sv
// Directed self-checking bench for sodor_mem_arbiter (default STARVE_LIMIT=4, TIMEOUT=64).
module tb_sodor_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_valid, imem_ready, imem_resp_valid;
    logic [31:0] imem_addr, imem_resp_data;
    logic        dmem_valid, dmem_ready, dmem_fcn, dmem_resp_valid;
    logic [31:0] dmem_addr, dmem_data, dmem_resp_data;
    logic [2:0]  dmem_typ;
    logic        mem_valid, mem_fcn, mem_resp_valid, timeout;
    logic [31:0] mem_addr, mem_data, mem_resp_data;
    logic [2:0]  mem_typ;

    int tests  = 0;
    int failed = 0;

    always #5 clock = ~clock;

    sodor_mem_arbiter dut (
        .clock                  (clock),
        .reset                  (reset),
        .io_imem_req_valid      (imem_valid),
        .io_imem_req_ready      (imem_ready),
        .io_imem_req_bits_addr  (imem_addr),
        .io_imem_resp_valid     (imem_resp_valid),
        .io_imem_resp_bits_data (imem_resp_data),
        .io_dmem_req_valid      (dmem_valid),
        .io_dmem_req_ready      (dmem_ready),
        .io_dmem_req_bits_addr  (dmem_addr),
        .io_dmem_req_bits_data  (dmem_data),
        .io_dmem_req_bits_fcn   (dmem_fcn),
        .io_dmem_req_bits_typ   (dmem_typ),
        .io_dmem_resp_valid     (dmem_resp_valid),
        .io_dmem_resp_bits_data (dmem_resp_data),
        .io_mem_req_valid       (mem_valid),
        .io_mem_req_bits_addr   (mem_addr),
        .io_mem_req_bits_data   (mem_data),
        .io_mem_req_bits_fcn    (mem_fcn),
        .io_mem_req_bits_typ    (mem_typ),
        .io_mem_resp_valid      (mem_resp_valid),
        .io_mem_resp_bits_data  (mem_resp_data),
        .io_timeout             (timeout)
    );

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        imem_valid = 1'b1;
        imem_addr = 32'h1000;
        tick();
        tick();
        #1;
        tests++;
        if (imem_ready !== 1'b0 || mem_valid !== 1'b0) begin
            failed++;
            $display("FAIL reset_grant: ready=%b mem_valid=%b, want 0/0", imem_ready, mem_valid);
        end
        tests++;
        if (timeout !== 1'b0) begin
            failed++;
            $display("FAIL reset_timeout: got %b want 0", timeout);
        end
        imem_valid = 1'b0;
        reset = 1'b0;
        tick();
        tests++;
        if (mem_valid !== 1'b0 || dmem_ready !== 1'b0) begin
            failed++;
            $display("FAIL idle_quiet: mem_valid=%b dmem_ready=%b, want 0/0", mem_valid, dmem_ready);
        end
    endtask

    task automatic test_imem_fetch();
        imem_valid = 1'b1;
        imem_addr = 32'h8000_0010;
        #1;
        tests++;
        if (imem_ready !== 1'b1 || dmem_ready !== 1'b0 || mem_valid !== 1'b1) begin
            failed++;
            $display("FAIL imem_grant: ir=%b dr=%b mv=%b, want 1/0/1", imem_ready, dmem_ready, mem_valid);
        end
        tests++;
        if (mem_addr !== 32'h8000_0010 || mem_fcn !== 1'b0 || mem_typ !== 3'd3 || mem_data !== 32'h0) begin
            failed++;
            $display("FAIL imem_fields: addr=%h fcn=%b typ=%0d data=%h, want 80000010/0/3/0",
                     mem_addr, mem_fcn, mem_typ, mem_data);
        end
        tick();
        imem_valid = 1'b0;
        #1;
        tests++;
        if (imem_resp_valid !== 1'b0 || mem_valid !== 1'b0) begin
            failed++;
            $display("FAIL imem_wait: resp=%b mv=%b, want 0/0", imem_resp_valid, mem_valid);
        end
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data = 32'hDEAD_BEEF;
        #1;
        tests++;
        if (imem_resp_valid !== 1'b1 || imem_resp_data !== 32'hDEAD_BEEF || dmem_resp_valid !== 1'b0) begin
            failed++;
            $display("FAIL imem_resp: iv=%b data=%h dv=%b, want 1/deadbeef/0",
                     imem_resp_valid, imem_resp_data, dmem_resp_valid);
        end
        tick();
        mem_resp_valid = 1'b0;
    endtask

    task automatic test_dmem_write();
        dmem_valid = 1'b1;
        dmem_addr = 32'h8000_0100;
        dmem_data = 32'h1234_5678;
        dmem_fcn = 1'b1;
        dmem_typ = 3'd3;
        #1;
        tests++;
        if (dmem_ready !== 1'b1 || imem_ready !== 1'b0 || mem_valid !== 1'b1) begin
            failed++;
            $display("FAIL dmem_grant: dr=%b ir=%b mv=%b, want 1/0/1", dmem_ready, imem_ready, mem_valid);
        end
        tests++;
        if (mem_addr !== 32'h8000_0100 || mem_data !== 32'h1234_5678 || mem_fcn !== 1'b1 || mem_typ !== 3'd3) begin
            failed++;
            $display("FAIL dmem_fields: addr=%h data=%h fcn=%b typ=%0d, want 80000100/12345678/1/3",
                     mem_addr, mem_data, mem_fcn, mem_typ);
        end
        tick();
        dmem_valid = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data = 32'hCAFE_0001;
        #1;
        tests++;
        if (dmem_resp_valid !== 1'b1 || dmem_resp_data !== 32'hCAFE_0001 || imem_resp_valid !== 1'b0) begin
            failed++;
            $display("FAIL dmem_resp: dv=%b data=%h iv=%b, want 1/cafe0001/0",
                     dmem_resp_valid, dmem_resp_data, imem_resp_valid);
        end
        tick();
        mem_resp_valid = 1'b0;
        dmem_fcn = 1'b0;
    endtask

    task automatic test_starvation();
        logic exp_i;
        imem_valid = 1'b1;
        dmem_valid = 1'b1;
        imem_addr = 32'h0000_0200;
        dmem_addr = 32'h0000_0300;
        for (int k = 0; k < 6; k++) begin
            exp_i = (k == 4);
            #1;
            tests++;
            if (imem_ready !== exp_i || dmem_ready !== !exp_i) begin
                failed++;
                $display("FAIL starve_grant%0d: ir=%b dr=%b, want %b/%b",
                         k, imem_ready, dmem_ready, exp_i, !exp_i);
            end
            tick();
            mem_resp_valid = 1'b1;
            mem_resp_data = 32'h100 + k;
            #1;
            tests++;
            if (imem_resp_valid !== exp_i || dmem_resp_valid !== !exp_i || mem_valid !== 1'b0) begin
                failed++;
                $display("FAIL starve_resp%0d: iv=%b dv=%b mv=%b, want %b/%b/0",
                         k, imem_resp_valid, dmem_resp_valid, mem_valid, exp_i, !exp_i);
            end
            tick();
            mem_resp_valid = 1'b0;
        end
        imem_valid = 1'b0;
        dmem_valid = 1'b0;
    endtask

    // Response arriving exactly on the timeout cycle is a normal response.
    task automatic test_resp_at_limit();
        dmem_valid = 1'b1;
        tick();
        dmem_valid = 1'b0;
        for (int k = 1; k < 64; k++) tick();
        mem_resp_valid = 1'b1;
        mem_resp_data = 32'hA5A5_0064;
        #1;
        tests++;
        if (dmem_resp_valid !== 1'b1 || dmem_resp_data !== 32'hA5A5_0064) begin
            failed++;
            $display("FAIL limit_resp: dv=%b data=%h, want 1/a5a50064", dmem_resp_valid, dmem_resp_data);
        end
        tick();
        mem_resp_valid = 1'b0;
        #1;
        tests++;
        if (timeout !== 1'b0) begin
            failed++;
            $display("FAIL limit_no_timeout: got %b want 0", timeout);
        end
    endtask

    task automatic test_timeout();
        logic early;
        early = 1'b0;
        mem_resp_data = 32'h5555_5555;
        dmem_valid = 1'b1;
        tick();
        dmem_valid = 1'b0;
        for (int k = 1; k < 64; k++) begin
            #1;
            if (dmem_resp_valid !== 1'b0) early = 1'b1;
            tick();
        end
        tests++;
        if (early !== 1'b0) begin
            failed++;
            $display("FAIL timeout_early: resp seen before cycle 64, want none");
        end
        #1;
        tests++;
        if (dmem_resp_valid !== 1'b1 || dmem_resp_data !== 32'h0 || imem_resp_valid !== 1'b0) begin
            failed++;
            $display("FAIL timeout_resp: dv=%b data=%h iv=%b, want 1/0/0",
                     dmem_resp_valid, dmem_resp_data, imem_resp_valid);
        end
        tick();
        tests++;
        if (timeout !== 1'b1) begin
            failed++;
            $display("FAIL timeout_flag: got %b want 1", timeout);
        end
        imem_valid = 1'b1;
        #1;
        tests++;
        if (imem_ready !== 1'b1) begin
            failed++;
            $display("FAIL timeout_idle: imem_ready=%b want 1", imem_ready);
        end
        tick();
        imem_valid = 1'b0;
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        tests++;
        if (timeout !== 1'b1) begin
            failed++;
            $display("FAIL timeout_sticky: got %b want 1", timeout);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tests++;
        if (timeout !== 1'b0) begin
            failed++;
            $display("FAIL timeout_cleared: got %b want 0", timeout);
        end
    endtask

    task automatic test_reset_mid();
        imem_valid = 1'b1;
        imem_addr = 32'h8000_0040;
        tick();
        imem_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data = 32'h7777_0000;
        #1;
        tests++;
        if (imem_resp_valid !== 1'b0 || dmem_resp_valid !== 1'b0) begin
            failed++;
            $display("FAIL reset_mid_drop: iv=%b dv=%b, want 0/0", imem_resp_valid, dmem_resp_valid);
        end
        tick();
        mem_resp_valid = 1'b0;
        imem_valid = 1'b1;
        #1;
        tests++;
        if (imem_ready !== 1'b1 || mem_addr !== 32'h8000_0040) begin
            failed++;
            $display("FAIL reset_mid_regrant: ir=%b addr=%h, want 1/80000040", imem_ready, mem_addr);
        end
        tick();
        imem_valid = 1'b0;
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
    endtask

    task automatic test_idle_resp();
        mem_resp_valid = 1'b1;
        mem_resp_data = 32'h0BAD_F00D;
        #1;
        tests++;
        if (imem_resp_valid !== 1'b0 || dmem_resp_valid !== 1'b0) begin
            failed++;
            $display("FAIL idle_resp: iv=%b dv=%b, want 0/0", imem_resp_valid, dmem_resp_valid);
        end
        tests++;
        if (imem_resp_data !== 32'h0BAD_F00D || dmem_resp_data !== 32'h0BAD_F00D) begin
            failed++;
            $display("FAIL idle_passthru: i=%h d=%h, want 0badf00d", imem_resp_data, dmem_resp_data);
        end
        tick();
        mem_resp_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        imem_valid = 1'b0;
        imem_addr = 32'h0;
        dmem_valid = 1'b0;
        dmem_addr = 32'h0;
        dmem_data = 32'h0;
        dmem_fcn = 1'b0;
        dmem_typ = 3'd0;
        mem_resp_valid = 1'b0;
        mem_resp_data = 32'h0;
        #1;
        test_reset();
        test_imem_fetch();
        test_dmem_write();
        test_starvation();
        test_resp_at_limit();
        test_timeout();
        test_reset_mid();
        test_idle_resp();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/sodor_mem_arbiter.md
SODOR_MEM_ARBITER -- requirements
Module: sodor_mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive IDLE-cycle imem losses before imem is forced to win (1..7).
REQ-002 SHALL have parameter TIMEOUT, default 64, meaning WAIT-state cycles before a transaction is aborted (2..127).
REQ-003 SHALL have port clock, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port io_imem_req_valid, input, 1, fetch request pending.
REQ-006 SHALL have port io_imem_req_ready, output, 1, fetch request accepted this cycle.
REQ-007 SHALL have port io_imem_req_bits_addr, input, 32, fetch address.
REQ-008 SHALL have ports io_imem_resp_valid, output, 1, and io_imem_resp_bits_data, output, 32, fetch response.
REQ-009 SHALL have port io_dmem_req_valid, input, 1, and io_dmem_req_ready, output, 1, data request handshake.
REQ-010 SHALL have ports io_dmem_req_bits_addr/data, input, 32 each; io_dmem_req_bits_fcn, input, 1 (1=write); io_dmem_req_bits_typ, input, 3.
REQ-011 SHALL have ports io_dmem_resp_valid, output, 1, and io_dmem_resp_bits_data, output, 32.
REQ-012 SHALL have ports io_mem_req_valid, output, 1; io_mem_req_bits_addr/data, output, 32; io_mem_req_bits_fcn, output, 1; io_mem_req_bits_typ, output, 3: shared scratchpad request.
REQ-013 SHALL have ports io_mem_resp_valid, input, 1, and io_mem_resp_bits_data, input, 32: shared scratchpad response.
REQ-014 SHALL have port io_timeout, output, 1, sticky abort flag.

Function
REQ-015 SHALL implement states IDLE, WAIT_I, WAIT_D; one transaction outstanding at most.
REQ-016 In IDLE, SHALL grant dmem if io_dmem_req_valid, unless starve count == STARVE_LIMIT and io_imem_req_valid, then imem; imem if only imem valid.
REQ-017 Grant SHALL be combinational: io_mem_req_valid=1, winner's ready=1, winner's fields driven on io_mem_req_bits_* in the same cycle; next state WAIT_I/WAIT_D.
REQ-018 Imem grant SHALL drive fcn=0, typ=3'd3, data=32'h0.
REQ-019 Outside an IDLE grant, io_mem_req_valid and both readies SHALL be 0; io_mem_req_bits_* SHALL carry dmem fields.
REQ-020 Starve counter (3 bits) SHALL increment, saturating, on each IDLE cycle with both valids and dmem granted; clear on imem grant.
REQ-021 In WAIT_x, io_mem_resp_valid=1 SHALL assert the owner's resp_valid the same cycle with data = io_mem_resp_bits_data; next state IDLE.
REQ-022 New grant SHALL occur no earlier than the cycle after the response (minimum 2 cycles per transaction).
REQ-023 Both resp_bits_data outputs SHALL pass io_mem_resp_bits_data through; only resp_valid is gated by ownership.
REQ-024 io_mem_resp_valid in IDLE SHALL be ignored (no resp_valid to either requester).
REQ-025 Wait counter (7 bits) SHALL clear on entry to WAIT_x and increment each WAIT cycle without response.
REQ-026 When wait counter reaches TIMEOUT-1 without response, SHALL assert owner's resp_valid with data 32'h0 that cycle, set io_timeout, return to IDLE.
REQ-027 Response and timeout in the same cycle SHALL be treated as a normal response; io_timeout not set.
REQ-028 Requesters SHALL hold valid and fields stable until ready; arbiter need not latch request fields.

Reset
REQ-029 On reset=1 at a clock edge: state IDLE, starve and wait counters 0, io_timeout 0.
REQ-030 During reset cycles all outputs except pass-through data SHALL be 0; a response arriving after mid-transaction reset SHALL be dropped per REQ-024.

Verification
REQ-031 imem only, addr 0x80000010, resp 2 cycles later data 0xDEADBEEF -> imem ready cycle 0, mem fcn=0 typ=3, imem_resp_valid with 0xDEADBEEF cycle 2, dmem_resp_valid 0.
REQ-032 both valid continuously, immediate responses, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,...
REQ-033 dmem write addr 0x80000100 data 0x12345678 fcn=1 -> mem fields match exactly; dmem_resp_valid on response.
REQ-034 grant dmem, never respond, TIMEOUT=64 -> dmem_resp_valid with 0x0 cycle 64 after grant, io_timeout=1 until reset.
REQ-035 reset asserted in WAIT_I, response arrives after reset release -> no resp_valid, state IDLE, next imem request granted normally.
REQ-036 io_mem_resp_valid pulsed in IDLE with no requests -> both resp_valid stay 0.
